// File: rtl/shared_buffer_arbiter.sv
// shared_buffer_arbiter
//   Round-robin ownership arbiter for the 676-bit shared buffer. This block sees
//   four clients:
//     0 = add_round (AR)
//     1 = BS2POLVECp (BS)
//     2 = Add_m_pack (AM)
//     3 = pol_mul (PO)
//   Only the owner's buffer enables reach the buffer. Data buses bypass this block.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   req[3:0], rel[3:0]   per-client ownership request / release
//   err_clr              clears the sticky error flags
//   *_i strobes          raw client buffer enables (PO_pol_load_coeff4x_i is a mode bit)
//   gated strobes        *_i AND the client's grant bit (combinational)
//   grant[3:0], owner    one-hot registered grant and its index (owner valid while busy)
//   busy                 an ownership is active
//   ops_cnt              saturating count of forwarded-strobe cycles in this ownership
//   err_illegal/err_src  sticky non-owner strobe flag and the first offender's index
//   err_timeout          sticky flag for a forced release on inactivity
module shared_buffer_arbiter #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       rel,
  input  logic             err_clr,
  input  logic             AR_buffer40_en_i,
  input  logic             AR_buffer64_en_i,
  input  logic             BS_buffer40_en_i,
  input  logic             BS_buffer64_en_i,
  input  logic             AM_buffer16_en_i,
  input  logic             PO_pol_load_coeff4x_i,
  input  logic             PO_poly_load_i,
  input  logic             PO_poly_shift_i,
  output logic             AR_buffer40_en,
  output logic             AR_buffer64_en,
  output logic             BS_buffer40_en,
  output logic             BS_buffer64_en,
  output logic             AM_buffer16_en,
  output logic             PO_pol_load_coeff4x,
  output logic             PO_poly_load,
  output logic             PO_poly_shift,
  output logic [3:0]       grant,
  output logic [1:0]       owner,
  output logic             busy,
  output logic [CNT_W-1:0] ops_cnt,
  output logic             err_illegal,
  output logic [1:0]       err_src,
  output logic             err_timeout
);

  localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StOwn, StDrain} state_e;

  state_e            r_state, w_state_next;
  logic [3:0]        r_grant;
  logic [1:0]        r_owner;
  logic [1:0]        r_ptr;
  logic [CNT_W-1:0]  r_ops;
  logic [IDLE_W-1:0] r_idle;
  logic              r_err_illegal;
  logic [1:0]        r_err_src;
  logic              r_err_timeout;

  logic [3:0]        w_strobe;
  logic [3:0]        w_illegal;
  logic              w_fwd;
  logic              w_found;
  logic [1:0]        w_winner;
  logic [1:0]        w_first_illegal;
  logic              w_rel;
  logic              w_timeout;
  logic              w_new_grant;
  logic              w_end_own;
  logic              w_force;
  logic              w_busy;
  logic [CNT_W-1:0]  w_ops_next;
  logic [IDLE_W-1:0] w_idle_next;
  logic              w_err_illegal_next;
  logic [1:0]        w_err_src_next;
  logic              w_err_timeout_next;

  // Per-client strobe activity. The PO coefficient mode bit is not an access,
  // so it neither counts as activity nor as an illegal strobe.
  assign w_strobe = {PO_poly_load_i | PO_poly_shift_i,
                     AM_buffer16_en_i,
                     BS_buffer40_en_i | BS_buffer64_en_i,
                     AR_buffer40_en_i | AR_buffer64_en_i};

  assign w_illegal = w_strobe & ~r_grant;
  assign w_fwd     = |(w_strobe & r_grant);

  assign AR_buffer40_en      = AR_buffer40_en_i      & r_grant[0];
  assign AR_buffer64_en      = AR_buffer64_en_i      & r_grant[0];
  assign BS_buffer40_en      = BS_buffer40_en_i      & r_grant[1];
  assign BS_buffer64_en      = BS_buffer64_en_i      & r_grant[1];
  assign AM_buffer16_en      = AM_buffer16_en_i      & r_grant[2];
  assign PO_pol_load_coeff4x = PO_pol_load_coeff4x_i & r_grant[3];
  assign PO_poly_load        = PO_poly_load_i        & r_grant[3];
  assign PO_poly_shift       = PO_poly_shift_i       & r_grant[3];

  // Round-robin pick: first requester at or above r_ptr, wrapping modulo 4.
  always_comb begin
    logic [1:0] idx;
    w_found  = 1'b0;
    w_winner = r_ptr;
    idx      = '0;
    for (int k = 0; k < 4; k++) begin
      idx = r_ptr + 2'(k);
      if (!w_found && req[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  // Lowest-index offender wins when several clients misbehave together.
  always_comb begin
    w_first_illegal = '0;
    for (int k = 3; k >= 0; k--) begin
      if (w_illegal[k]) w_first_illegal = 2'(k);
    end
  end

  assign w_rel     = rel[r_owner];
  assign w_timeout = (TIMEOUT != 0) && (r_state == StOwn) && !w_fwd &&
                     (r_idle == IDLE_W'(TIMEOUT - 1));

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_found) w_state_next = StOwn;
      StOwn:   if (w_rel || w_timeout) w_state_next = StDrain;
      StDrain: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM: outputs / control strobes
  always_comb begin
    w_busy      = (r_state == StOwn);
    w_new_grant = (r_state == StIdle) && w_found;
    w_end_own   = w_busy && (w_rel || w_timeout);
    // A release in the same cycle as the timeout is a normal release.
    w_force     = w_busy && w_timeout && !w_rel;
  end

  // Counters and error next-state
  always_comb begin
    w_ops_next  = r_ops;
    w_idle_next = r_idle;
    if (w_new_grant) begin
      w_ops_next  = '0;
      w_idle_next = '0;
    end else if (w_busy) begin
      if (w_fwd) begin
        w_idle_next = '0;
        if (r_ops != '1) w_ops_next = r_ops + CNT_W'(1);
      end else if (r_idle != '1) begin
        w_idle_next = r_idle + IDLE_W'(1);
      end
    end

    w_err_illegal_next = (r_err_illegal & ~err_clr) | (|w_illegal);
    w_err_src_next     = err_clr ? 2'd0 : r_err_src;
    if ((|w_illegal) && (!r_err_illegal || err_clr)) w_err_src_next = w_first_illegal;
    w_err_timeout_next = (r_err_timeout & ~err_clr) | w_force;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant       <= '0;
      r_owner       <= '0;
      r_ptr         <= '0;
      r_ops         <= '0;
      r_idle        <= '0;
      r_err_illegal <= 1'b0;
      r_err_src     <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_new_grant) begin
        r_grant <= 4'b0001 << w_winner;
        r_owner <= w_winner;
        r_ptr   <= w_winner + 2'd1;
      end else if (w_end_own) begin
        r_grant <= '0;
      end
      r_ops         <= w_ops_next;
      r_idle        <= w_idle_next;
      r_err_illegal <= w_err_illegal_next;
      r_err_src     <= w_err_src_next;
      r_err_timeout <= w_err_timeout_next;
    end
  end

  assign grant       = r_grant;
  assign owner       = r_owner;
  assign busy        = w_busy;
  assign ops_cnt     = r_ops;
  assign err_illegal = r_err_illegal;
  assign err_src     = r_err_src;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_shared_buffer_arbiter.sv
// Directed bench for shared_buffer_arbiter. Grant transitions are checked by a
// scoreboard monitor; status outputs are checked inline.
module tb_shared_buffer_arbiter;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] rel = '0;
  logic err_clr = 1'b0;
  logic ar40_i = 1'b0, ar64_i = 1'b0, bs40_i = 1'b0, bs64_i = 1'b0, am16_i = 1'b0;
  logic coeff_i = 1'b0, pload_i = 1'b0, pshift_i = 1'b0;
  logic AR_buffer40_en, AR_buffer64_en, BS_buffer40_en, BS_buffer64_en, AM_buffer16_en;
  logic PO_pol_load_coeff4x, PO_poly_load, PO_poly_shift;
  logic [3:0] grant;
  logic [1:0] owner;
  logic busy;
  logic [CNT_W-1:0] ops_cnt;
  logic err_illegal, err_timeout;
  logic [1:0] err_src;

  int checks = 0;
  int errors = 0;

  shared_buffer_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .err_clr(err_clr),
    .AR_buffer40_en_i(ar40_i), .AR_buffer64_en_i(ar64_i),
    .BS_buffer40_en_i(bs40_i), .BS_buffer64_en_i(bs64_i),
    .AM_buffer16_en_i(am16_i), .PO_pol_load_coeff4x_i(coeff_i),
    .PO_poly_load_i(pload_i), .PO_poly_shift_i(pshift_i),
    .AR_buffer40_en(AR_buffer40_en), .AR_buffer64_en(AR_buffer64_en),
    .BS_buffer40_en(BS_buffer40_en), .BS_buffer64_en(BS_buffer64_en),
    .AM_buffer16_en(AM_buffer16_en), .PO_pol_load_coeff4x(PO_pol_load_coeff4x),
    .PO_poly_load(PO_poly_load), .PO_poly_shift(PO_poly_shift),
    .grant(grant), .owner(owner), .busy(busy), .ops_cnt(ops_cnt),
    .err_illegal(err_illegal), .err_src(err_src), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] o;
  } gev_t;

  gev_t exp_q[$];

  task automatic expect_grant(input logic [3:0] g, input logic [1:0] o);
    exp_q.push_back({g, o});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_strobe(input int c, input logic v);
    case (c)
      0: ar40_i = v;
      1: bs64_i = v;
      2: am16_i = v;
      default: pload_i = v;
    endcase
  endtask

  function automatic logic strobe_out(input int c);
    case (c)
      0: return AR_buffer40_en;
      1: return BS_buffer64_en;
      2: return AM_buffer16_en;
      default: return PO_poly_load;
    endcase
  endfunction

  // Scoreboard monitor: every change of grant must match the next expected event.
  logic [3:0] prev_grant = '0;
  always @(negedge clk) begin
    gev_t e;
    if (grant !== prev_grant) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: got grant=%b expected no change", grant);
      end else begin
        e = exp_q.pop_front();
        if (grant !== e.g || (e.g != 4'b0 && owner !== e.o)) begin
          errors++;
          $display("FAIL grant_seq: got grant=%b owner=%0d expected grant=%b owner=%0d",
                   grant, owner, e.g, e.o);
        end
      end
      prev_grant = grant;
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_ops", ops_cnt, 0);
    check("rst_errs", {err_illegal, err_src, err_timeout}, 0);

    // Single client AM
    req = 4'b0100;
    expect_grant(4'b0100, 2'd2);
    step();
    req = '0;
    check("t1_grant", grant, 4'b0100);
    check("t1_owner", owner, 2);
    check("t1_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      am16_i = 1'b1;
      #1 check("t1_am_on", AM_buffer16_en, 1);
      step();
      am16_i = 1'b0;
      #1 check("t1_am_off", AM_buffer16_en, 0);
      step();
    end
    check("t1_ops", ops_cnt, 5);
    rel = 4'b0100;
    expect_grant(4'b0000, 2'd0);
    #1 check("t1_grant_at_rel", grant, 4'b0100);
    step();
    rel = '0;
    check("t1_drain_grant", grant, 0);
    check("t1_drain_busy", busy, 0);
    step();
    check("t1_ops_hold", ops_cnt, 5);

    rst = 1'b1;
    #1 rst = 1'b0;
    check("t2_ops_reset", ops_cnt, 0);

    // Round robin from pointer 0: AR, BS, AM, PO, AR
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int c;
      c = k % 4;
      expect_grant(4'(1 << c), 2'(c));
      expect_grant(4'b0000, 2'd0);
      step();
      check("t2_owner", owner, c);
      set_strobe(c, 1'b1);
      #1 check("t2_fwd", strobe_out(c), 1);
      step();
      set_strobe(c, 1'b0);
      check("t2_ops", ops_cnt, 1);
      rel = 4'(1 << c);
      step();
      rel = '0;
      check("t2_gap1", grant, 0);
      step();
      check("t2_gap2", grant, 0);
    end
    req = '0;

    // Illegal access while PO owns
    req = 4'b1000;
    expect_grant(4'b1000, 2'd3);
    step();
    req = '0;
    ar40_i = 1'b1; bs64_i = 1'b1; coeff_i = 1'b1;
    #1;
    check("t3_ar_blocked", AR_buffer40_en, 0);
    check("t3_bs_blocked", BS_buffer64_en, 0);
    check("t3_coeff_fwd", PO_pol_load_coeff4x, 1);
    step();
    ar40_i = 1'b0; bs64_i = 1'b0; coeff_i = 1'b0;
    check("t3_err", err_illegal, 1);
    check("t3_src", err_src, 0);
    bs64_i = 1'b1;
    step();
    bs64_i = 1'b0;
    check("t3_src_sticky", err_src, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t3_clr", {err_illegal, err_src, err_timeout}, 0);
    err_clr = 1'b1; bs64_i = 1'b1;
    step();
    err_clr = 1'b0; bs64_i = 1'b0;
    check("t3_err_wins_clr", err_illegal, 1);
    check("t3_src_bs", err_src, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t3_clr2", err_illegal, 0);
    rel = 4'b1000;
    expect_grant(4'b0000, 2'd0);
    step();
    rel = '0;
    coeff_i = 1'b1;
    #1 check("t3_coeff_gated", PO_pol_load_coeff4x, 0);
    step();
    coeff_i = 1'b0;
    check("t3_coeff_not_illegal", err_illegal, 0);

    // Timeout: AR owns idle, BS waiting
    req = 4'b0011;
    expect_grant(4'b0001, 2'd0);
    step();
    check("t4_ar_grant", grant, 4'b0001);
    repeat (7) step();
    check("t4_still_owned", grant, 4'b0001);
    check("t4_no_timeout_yet", err_timeout, 0);
    expect_grant(4'b0000, 2'd0);
    expect_grant(4'b0010, 2'd1);
    step();
    check("t4_forced", grant, 0);
    check("t4_err_timeout", err_timeout, 1);
    step();
    check("t4_idle", grant, 0);
    step();
    req = '0;
    check("t4_bs_grant", grant, 4'b0010);
    rel = 4'b0010; err_clr = 1'b1;
    expect_grant(4'b0000, 2'd0);
    step();
    rel = '0; err_clr = 1'b0;
    check("t4_clr", err_timeout, 0);
    step();

    // Saturation and strobe together with release
    req = 4'b1000;
    expect_grant(4'b1000, 2'd3);
    step();
    req = '0;
    pshift_i = 1'b1;
    repeat (14) step();
    check("t5_ops14", ops_cnt, 14);
    repeat (5) step();
    check("t5_ops_sat", ops_cnt, 15);
    rel = 4'b1000;
    expect_grant(4'b0000, 2'd0);
    #1 check("t5_fwd_with_rel", PO_poly_shift, 1);
    step();
    pshift_i = 1'b0; rel = '0;
    check("t5_ops_final", ops_cnt, 15);
    check("t5_released", grant, 0);
    step();

    // Asynchronous reset mid-ownership
    req = 4'b1000;
    expect_grant(4'b1000, 2'd3);
    step();
    req = '0;
    pshift_i = 1'b1;
    step();
    check("t6_ops1", ops_cnt, 1);
    #1 check("t6_shift_on", PO_poly_shift, 1);
    expect_grant(4'b0000, 2'd0);
    rst = 1'b1;
    #1;
    check("t6_shift_drop", PO_poly_shift, 0);
    check("t6_grant_drop", grant, 0);
    check("t6_ops_clr", ops_cnt, 0);
    check("t6_busy", busy, 0);
    pshift_i = 1'b0;
    rst = 1'b0;
    repeat (2) step();
    check("t6_no_regrant", grant, 0);

    repeat (2) step();
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shared_buffer_arbiter.md
Name: shared_buffer_arbiter

Overview:
- Owns access control for the 676-bit shared buffer used by add_round (AR), BS2POLVECp (BS), Add_m_pack (AM) and pol_mul (PO).
- Grants exclusive ownership to one client at a time through a round-robin req/grant/release handshake.
- Forwards only the owner's buffer strobes; blocks and flags strobes from any other client.
- Enforces an inactivity timeout and counts the buffer operations performed in the current ownership. Data buses bypass this block; only enables are gated.

Parameters:
- TIMEOUT, 1024, idle owner cycles (no forwarded strobe) before forced release; 0 disables the timeout.
- CNT_W, 16, width of ops_cnt.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req  in  4  ownership request per client; bit0=AR, bit1=BS, bit2=AM, bit3=PO
- rel  in  4  ownership release per client, same bit order
- err_clr  in  1  clears sticky error flags
- AR_buffer40_en_i, AR_buffer64_en_i  in  1 each  AR strobes
- BS_buffer40_en_i, BS_buffer64_en_i  in  1 each  BS strobes
- AM_buffer16_en_i  in  1  AM strobe
- PO_pol_load_coeff4x_i, PO_poly_load_i, PO_poly_shift_i  in  1 each  PO mode and strobes
- AR_buffer40_en, AR_buffer64_en, BS_buffer40_en, BS_buffer64_en, AM_buffer16_en, PO_pol_load_coeff4x, PO_poly_load, PO_poly_shift  out  1 each  gated strobes to the buffer
- grant  out  4  one-hot registered grant
- owner  out  2  index of the granted client; valid while busy=1
- busy  out  1  high in state OWN
- ops_cnt  out  CNT_W  forwarded strobe cycles in the current ownership
- err_illegal  out  1  sticky: a non-owner asserted a strobe
- err_src  out  2  index of the first illegal client since the last clear
- err_timeout  out  1  sticky: a forced release occurred

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, grant=0, owner=0, busy=0, ops_cnt=0, all errors 0, RR pointer=0 (AR highest priority). Gated strobes go to 0 at once because grant=0.
- FSM states:
  - IDLE: if req!=0, pick the first set bit scanning from ptr upward, modulo 4. Next cycle: grant=onehot(winner), owner=winner, ptr=winner+1, ops_cnt=0, go to OWN.
  - OWN: if rel[owner]=1 or the timeout fires, go to DRAIN and clear grant next cycle. rel bits from non-owners are ignored.
  - DRAIN: one dead cycle with grant=0, then IDLE.
- Latencies:
  - Request sampled at cycle n gives grant at n+1.
  - Release at m: grant still high during m, low at m+1.
  - Earliest next grant is m+3.
- Strobe gating is combinational: each output = input AND grant bit of its client. Zero latency; PO_pol_load_coeff4x is gated the same way.
- Strobe and rel in the same cycle: the strobe is forwarded.
- The owner may assert several of its strobes in one cycle. They are forwarded unchanged; the buffer's own priority resolves them.
- Illegal access:
  - Any strobe input (excluding PO_pol_load_coeff4x_i) from a client whose grant bit is 0 is blocked.
  - It sets err_illegal on the next edge.
  - err_src is latched only if err_illegal was 0. If several clients offend in the same cycle, the lowest index is latched.
  - This also applies in IDLE and DRAIN.
- ops_cnt:
  - Increments by 1 per OWN cycle with at least one forwarded strobe.
  - Saturates at all-ones and holds its value through DRAIN and IDLE.
  - Cleared on a new grant.
- Timeout:
  - An idle counter resets on every forwarded strobe and on grant.
  - When it reaches TIMEOUT-1 with no strobe, the FSM goes to DRAIN and err_timeout is set.
- err_clr clears err_illegal, err_src and err_timeout. A new error in the same cycle as err_clr wins (the flag stays set).
- Fairness: the previous owner keeps its req asserted but is served only after the other requesters, because the pointer has moved past it.
- Reset mid-ownership: the owner loses its grant immediately; clients must re-request after reset.

Test Plan:
- Single client: reset, req=0100 at cycle 2 -> grant=0100 and owner=2 at cycle 3. AM_buffer16_en_i pulsed 5 cycles -> AM_buffer16_en mirrors the pulses, ops_cnt=5. rel[2] at cycle 10 -> grant=0 at 11, IDLE at 12.
- Round robin: req=1111 held with each owner releasing after 1 strobe -> grant order AR, BS, AM, PO, AR, with 2 idle cycles between grants.
- Illegal access: PO owns; BS_buffer64_en_i and AR_buffer40_en_i asserted -> both outputs stay 0, err_illegal=1, err_src=0. err_clr -> all flags 0.
- Timeout: TIMEOUT=8, AR granted, no strobes -> forced release after 8 OWN cycles, err_timeout=1. BS req pending -> BS granted 2 cycles later.
- Reset mid-op: PO owns with PO_poly_shift_i high; rst asserted between clock edges -> PO_poly_shift and grant drop immediately, ops_cnt=0.
- Boundary: CNT_W=4 with 20 strobes -> ops_cnt saturates at 15. Strobe in the same cycle as rel -> forwarded.
